// File: rtl/hc_csr_bank_if.sv
// -----------------------------------------------------------------------------
// hc_csr_bank_if
//   MMIO request/response bundle between the host shell and hc_csr_bank.
//
//   Request side (host -> bank):
//     req_address    16-bit 32-bit-word address (byte offset >> 2)
//     req_length     access width: 2'b00 = 4 bytes, otherwise 8 bytes
//     req_tid        transaction id, echoed on the read response
//     req_data       write data (4-byte writes carry their data in [31:0])
//     mmio_rd_valid  read request strobe
//     mmio_wr_valid  write request strobe
//
//   Response side (bank -> host):
//     rsp_mmio_rd_valid  one-cycle read response strobe
//     rsp_tid            tid of the read being answered
//     rsp_data           full 64-bit register contents
// -----------------------------------------------------------------------------
interface hc_csr_bank_if;
  logic [15:0] req_address;
  logic [1:0]  req_length;
  logic [8:0]  req_tid;
  logic [63:0] req_data;
  logic        mmio_rd_valid;
  logic        mmio_wr_valid;

  logic        rsp_mmio_rd_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  // Host side: issues requests, consumes responses.
  modport master (
    output req_address, req_length, req_tid, req_data, mmio_rd_valid, mmio_wr_valid,
    input  rsp_mmio_rd_valid, rsp_tid, rsp_data
  );

  // Register bank side: consumes requests, issues responses.
  modport slave (
    input  req_address, req_length, req_tid, req_data, mmio_rd_valid, mmio_wr_valid,
    output rsp_mmio_rd_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/hc_csr_bank.sv
// -----------------------------------------------------------------------------
// hc_csr_bank
//   MMIO register bank and control sequencer for a HardCloud accelerator.
//   Decodes host MMIO writes into a table of NUM_BUFFERS address/size pairs,
//   a DSM base register and a small control FSM, and answers MMIO reads of
//   the DFH, AFU ID, STATUS and every writable CSR.
//
//   Byte map (8-byte registers):
//     0x000 DFH (RO)       0x008 AFU_ID low      0x010 AFU_ID high
//     0x100 STATUS (RO)    0x110 DSM_BASE (RW)   0x118 CONTROL (WO, reads 0)
//     BUFFER_BASE + 16*i     buffer i address (RW, 64b)
//     BUFFER_BASE + 16*i + 8 buffer i size    (RW, 32b)
//   Everything else, and anything at or above 0x400, reads 0 / drops writes.
//   BUFFER_BASE is expected to be 16-byte aligned.
//
//   Ports:
//     clk        single clock
//     SoftReset  synchronous active-high reset
//     mmio       request/response bundle (slave side)
//     buf_addr   per-buffer base addresses
//     buf_size   per-buffer sizes in bytes
//     dsm_base   DSM base address
//     afu_rst    accelerator reset level, high while in C_RESET
//     start      one-cycle pulse on entering C_RUN by a start command
//     stop       one-cycle pulse on a stop command out of C_RUN
//     done       accelerator completion pulse
// -----------------------------------------------------------------------------
module hc_csr_bank #(
  parameter int unsigned  NUM_BUFFERS = 3,
  parameter logic [127:0] AFU_ID      = 128'h0,
  parameter logic [15:0]  BUFFER_BASE = 16'h120
) (
  input  logic                         clk,
  input  logic                         SoftReset,
  hc_csr_bank_if.slave                 mmio,
  output logic [NUM_BUFFERS-1:0][63:0] buf_addr,
  output logic [NUM_BUFFERS-1:0][31:0] buf_size,
  output logic [63:0]                  dsm_base,
  output logic                         afu_rst,
  output logic                         start,
  output logic                         stop,
  input  logic                         done
);

  // Register indices in 8-byte units (byte offset >> 3).
  localparam logic [14:0] QW_DFH      = 15'h000;
  localparam logic [14:0] QW_ID_L     = 15'h001;
  localparam logic [14:0] QW_ID_H     = 15'h002;
  localparam logic [14:0] QW_STATUS   = 15'h020;
  localparam logic [14:0] QW_DSM      = 15'h022;
  localparam logic [14:0] QW_CTRL     = 15'h023;
  localparam logic [14:0] QW_TBL_BASE = {2'b00, BUFFER_BASE[15:3]};
  localparam logic [14:0] TBL_QWORDS  = 15'(2 * NUM_BUFFERS);

  // AFU feature type in [63:60], end-of-list in [40].
  localparam logic [63:0] DFH_VALUE   = 64'h1000_0100_0000_0000;

  localparam logic [31:0] CODE_RESET  = 32'h0;
  localparam logic [31:0] CODE_IDLE   = 32'h1;
  localparam logic [31:0] CODE_START  = 32'h3;
  localparam logic [31:0] CODE_STOP   = 32'h7;

  typedef enum logic [1:0] {
    C_RESET = 2'd0,
    C_IDLE  = 2'd1,
    C_RUN   = 2'd2,
    C_DONE  = 2'd3
  } ctrl_state_t;

  ctrl_state_t state_reg;
  logic        wr_err_reg;
  logic        afu_rst_reg;
  logic        start_reg;
  logic        stop_reg;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [14:0] qw;          // 8-byte register index
  logic        half_hi;     // word-address bit 0: upper 32b half
  logic        is_4b;
  logic [14:0] tbl_rel;     // register index relative to the buffer table
  logic [3:0]  tbl_idx;
  logic        tbl_is_size;
  logic        sel_dfh, sel_id_l, sel_id_h, sel_status, sel_dsm, sel_ctrl;
  logic        fixed_hit;
  logic        sel_tbl;

  assign qw          = mmio.req_address[15:1];
  assign half_hi     = mmio.req_address[0];
  assign is_4b       = (mmio.req_length == 2'b00);
  assign tbl_rel     = qw - QW_TBL_BASE;
  assign tbl_idx     = tbl_rel[4:1];
  assign tbl_is_size = tbl_rel[0];

  assign sel_dfh    = (qw == QW_DFH);
  assign sel_id_l   = (qw == QW_ID_L);
  assign sel_id_h   = (qw == QW_ID_H);
  assign sel_status = (qw == QW_STATUS);
  assign sel_dsm    = (qw == QW_DSM);
  // CONTROL is only 32 bits wide; a 4B access to its upper half is unmapped.
  assign sel_ctrl   = (qw == QW_CTRL) && !(is_4b && half_hi);
  assign fixed_hit  = sel_dfh | sel_id_l | sel_id_h | sel_status | sel_dsm | (qw == QW_CTRL);

  // The fixed registers win if a BUFFER_BASE choice ever overlaps them;
  // the table is also clipped at the 0x400 end of the CSR window.
  assign sel_tbl = (qw >= QW_TBL_BASE) && (tbl_rel < TBL_QWORDS) &&
                   (mmio.req_address[15:8] == 8'h00) && !fixed_hit;

  // ---------------------------------------------------------------------------
  // Write strobes and write protection
  // ---------------------------------------------------------------------------
  logic run_lock;
  logic prot_hit;
  logic ctrl_we;
  logic dsm_we;
  logic tbl_we;

  assign run_lock = (state_reg == C_RUN);
  assign prot_hit = mmio.mmio_wr_valid && (sel_dsm || sel_tbl) && run_lock;
  assign ctrl_we  = mmio.mmio_wr_valid && sel_ctrl;
  assign dsm_we   = mmio.mmio_wr_valid && sel_dsm && !run_lock;
  assign tbl_we   = mmio.mmio_wr_valid && sel_tbl && !run_lock;

  // 8B writes replace the whole register; 4B writes replace one half with
  // data[31:0] and keep the other half.
  function automatic logic [63:0] merge_write(
    input logic [63:0] old_val,
    input logic [63:0] wr_data,
    input logic        narrow,
    input logic        upper
  );
    logic [63:0] result;
    result = wr_data;
    if (narrow) begin
      result = upper ? {wr_data[31:0], old_val[31:0]} : {old_val[63:32], wr_data[31:0]};
    end
    return result;
  endfunction

  // ---------------------------------------------------------------------------
  // DSM base
  // ---------------------------------------------------------------------------
  logic [63:0] dsm_base_reg;

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      dsm_base_reg <= '0;
    end else if (dsm_we) begin
      dsm_base_reg <= merge_write(dsm_base_reg, mmio.req_data, is_4b, half_hi);
    end
  end

  assign dsm_base = dsm_base_reg;

  // ---------------------------------------------------------------------------
  // Buffer table. The read-side views are padded to 16 entries so the
  // 4-bit table index can select them directly; unused slots read 0.
  // ---------------------------------------------------------------------------
  logic [63:0] addr_rd [16];
  logic [31:0] size_rd [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_buf
    if (gi < NUM_BUFFERS) begin : g_used
      logic [63:0] addr_reg;
      logic [31:0] size_reg;
      logic        entry_we;

      assign entry_we = tbl_we && (tbl_idx == 4'(gi));

      always_ff @(posedge clk) begin
        if (SoftReset) begin
          addr_reg <= '0;
          size_reg <= '0;
        end else if (entry_we) begin
          if (!tbl_is_size) begin
            addr_reg <= merge_write(addr_reg, mmio.req_data, is_4b, half_hi);
          end else if (!(is_4b && half_hi)) begin
            // Size is 32 bits: any write reaching the low half loads
            // data[31:0]; writes aimed only at the high half are dropped.
            size_reg <= mmio.req_data[31:0];
          end
        end
      end

      assign buf_addr[gi] = addr_reg;
      assign buf_size[gi] = size_reg;
      assign addr_rd[gi]  = addr_reg;
      assign size_rd[gi]  = size_reg;
    end else begin : g_unused
      assign addr_rd[gi] = '0;
      assign size_rd[gi] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. Outputs are registered alongside the state so that a
  // control write at cycle N shows its effect on every output at N+1.
  // A control write in the same cycle as done wins; done is discarded.
  // ---------------------------------------------------------------------------
  logic [31:0] ctrl_code;
  assign ctrl_code = mmio.req_data[31:0];

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state_reg   <= C_RESET;
      afu_rst_reg <= 1'b1;
      start_reg   <= 1'b0;
      stop_reg    <= 1'b0;
      wr_err_reg  <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
      if (ctrl_we) begin
        case (ctrl_code)
          CODE_RESET: begin
            // Buffer table and DSM base deliberately survive this.
            state_reg   <= C_RESET;
            afu_rst_reg <= 1'b1;
          end
          CODE_IDLE: begin
            state_reg   <= C_IDLE;
            afu_rst_reg <= 1'b0;
            wr_err_reg  <= 1'b0;
          end
          CODE_START: begin
            if (state_reg == C_IDLE || state_reg == C_DONE) begin
              state_reg <= C_RUN;
              start_reg <= 1'b1;
            end
          end
          CODE_STOP: begin
            if (state_reg == C_RUN) begin
              state_reg <= C_IDLE;
              stop_reg  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end else if (done && state_reg == C_RUN) begin
        state_reg <= C_DONE;
      end

      // Never coincides with a control write (one request per cycle).
      if (prot_hit) begin
        wr_err_reg <= 1'b1;
      end
    end
  end

  assign afu_rst = afu_rst_reg;
  assign start   = start_reg;
  assign stop    = stop_reg;

  // ---------------------------------------------------------------------------
  // Read path: combinational select, registered response. STATUS therefore
  // reports the state held during the request cycle.
  // ---------------------------------------------------------------------------
  logic [63:0] status_val;
  logic [63:0] rd_data;

  assign status_val = {58'h0, state_reg, 1'b0, wr_err_reg,
                       state_reg == C_DONE, state_reg == C_RUN};

  always_comb begin
    rd_data = '0;
    if (sel_dfh) begin
      rd_data = DFH_VALUE;
    end else if (sel_id_l) begin
      rd_data = AFU_ID[63:0];
    end else if (sel_id_h) begin
      rd_data = AFU_ID[127:64];
    end else if (sel_status) begin
      rd_data = status_val;
    end else if (sel_dsm) begin
      rd_data = dsm_base_reg;
    end else if (sel_tbl) begin
      rd_data = tbl_is_size ? {32'h0, size_rd[tbl_idx]} : addr_rd[tbl_idx];
    end
  end

  logic        rsp_valid_reg;
  logic [8:0]  rsp_tid_reg;
  logic [63:0] rsp_data_reg;

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      rsp_valid_reg <= 1'b0;
      rsp_tid_reg   <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= mmio.mmio_rd_valid;
      if (mmio.mmio_rd_valid) begin
        rsp_tid_reg  <= mmio.req_tid;
        rsp_data_reg <= rd_data;
      end
    end
  end

  assign mmio.rsp_mmio_rd_valid = rsp_valid_reg;
  assign mmio.rsp_tid           = rsp_tid_reg;
  assign mmio.rsp_data          = rsp_data_reg;

endmodule

// File: tb/tb_hc_csr_bank.sv
// -----------------------------------------------------------------------------
// tb_hc_csr_bank
//   Directed scenarios followed by randomized MMIO traffic, all checked
//   against a behavioural model of the register map and control sequencer.
// -----------------------------------------------------------------------------
module tb_hc_csr_bank;
  localparam int           NB        = 4;
  localparam logic [127:0] TB_AFU_ID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  DFH_EXP   = 64'h1000_0100_0000_0000;
  localparam int           TBL_BASE  = 'h120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                soft_reset;
  logic                done;
  logic [NB-1:0][63:0] buf_addr;
  logic [NB-1:0][31:0] buf_size;
  logic [63:0]         dsm_base;
  logic                afu_rst;
  logic                start;
  logic                stop;

  hc_csr_bank_if mmio_if ();

  hc_csr_bank #(
    .NUM_BUFFERS(NB),
    .AFU_ID     (TB_AFU_ID),
    .BUFFER_BASE(16'h120)
  ) dut (
    .clk      (clk),
    .SoftReset(soft_reset),
    .mmio     (mmio_if),
    .buf_addr (buf_addr),
    .buf_size (buf_size),
    .dsm_base (dsm_base),
    .afu_rst  (afu_rst),
    .start    (start),
    .stop     (stop),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // ---------------- behavioural model ----------------
  logic [63:0] m_addr [NB];
  logic [31:0] m_size [NB];
  logic [63:0] m_dsm;
  int          m_state;      // 0 reset, 1 idle, 2 run, 3 done
  bit          m_wr_err;
  bit          exp_start;
  bit          exp_stop;
  logic [63:0] last_rsp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_addr[i] = '0;
      m_size[i] = '0;
    end
    m_dsm     = '0;
    m_state   = 0;
    m_wr_err  = 0;
    exp_start = 0;
    exp_stop  = 0;
  endfunction

  function automatic void model_control(input logic [31:0] code);
    if (code == 32'h0) begin
      m_state = 0;
    end else if (code == 32'h1) begin
      m_state  = 1;
      m_wr_err = 0;
    end else if (code == 32'h3) begin
      if (m_state == 1 || m_state == 3) begin
        m_state   = 2;
        exp_start = 1;
      end
    end else if (code == 32'h7) begin
      if (m_state == 2) begin
        m_state  = 1;
        exp_stop = 1;
      end
    end
  endfunction

  // Returns 1 when the write landed on CONTROL (which swallows a same-cycle done).
  function automatic bit model_write(input logic [17:0] off, input bit is8, input logic [63:0] d);
    int          qoff;
    int          rel;
    bit          hi;
    logic [63:0] lo32;
    qoff = int'(off) & ~7;
    hi   = off[2];
    lo32 = {32'h0, d[31:0]};
    if (qoff >= 'h400) return 0;
    if (qoff == 'h110) begin
      if (m_state == 2) m_wr_err = 1;
      else if (is8) m_dsm = d;
      else if (hi) m_dsm = (m_dsm & 64'h0000_0000_FFFF_FFFF) | (lo32 << 32);
      else m_dsm = (m_dsm & 64'hFFFF_FFFF_0000_0000) | lo32;
      return 0;
    end
    if (qoff == 'h118) begin
      if (is8 || !hi) begin
        model_control(d[31:0]);
        return 1;
      end
      return 0;
    end
    rel = qoff - TBL_BASE;
    if (rel >= 0 && rel < 16 * NB) begin
      if (m_state == 2) begin
        m_wr_err = 1;
      end else if (rel % 16 == 8) begin
        if (is8 || !hi) m_size[rel / 16] = d[31:0];
      end else if (is8) begin
        m_addr[rel / 16] = d;
      end else if (hi) begin
        m_addr[rel / 16] = (m_addr[rel / 16] & 64'h0000_0000_FFFF_FFFF) | (lo32 << 32);
      end else begin
        m_addr[rel / 16] = (m_addr[rel / 16] & 64'hFFFF_FFFF_0000_0000) | lo32;
      end
    end
    return 0;
  endfunction

  function automatic logic [63:0] model_read(input logic [17:0] off);
    int qoff;
    int rel;
    qoff = int'(off) & ~7;
    if (qoff >= 'h400) return 64'h0;
    if (qoff == 'h000) return DFH_EXP;
    if (qoff == 'h008) return TB_AFU_ID[63:0];
    if (qoff == 'h010) return TB_AFU_ID[127:64];
    if (qoff == 'h100)
      return 64'(m_state * 16 + (m_wr_err ? 4 : 0) + (m_state == 3 ? 2 : 0) + (m_state == 2 ? 1 : 0));
    if (qoff == 'h110) return m_dsm;
    rel = qoff - TBL_BASE;
    if (rel >= 0 && rel < 16 * NB) begin
      if (rel % 16 == 8) return {32'h0, m_size[rel / 16]};
      return m_addr[rel / 16];
    end
    return 64'h0;
  endfunction

  task automatic check_outputs(input string tag, input bit rsp_exp);
    for (int i = 0; i < NB; i++) begin
      check_val($sformatf("%s/buf_addr%0d", tag, i), buf_addr[i], m_addr[i]);
      check_val($sformatf("%s/buf_size%0d", tag, i), {32'h0, buf_size[i]}, {32'h0, m_size[i]});
    end
    check_val({tag, "/dsm_base"}, dsm_base, m_dsm);
    check_val({tag, "/afu_rst"}, {63'h0, afu_rst}, {63'h0, m_state == 0});
    check_val({tag, "/start"}, {63'h0, start}, {63'h0, exp_start});
    check_val({tag, "/stop"}, {63'h0, stop}, {63'h0, exp_stop});
    check_val({tag, "/rsp_valid"}, {63'h0, mmio_if.rsp_mmio_rd_valid}, {63'h0, rsp_exp});
  endtask

  // All tasks start and end at posedge+1: they drive one cycle of inputs
  // and sample the registered results one clock later.
  task automatic do_write(input logic [17:0] off, input bit is8, input logic [63:0] d,
                          input bit with_done, input string tag);
    bit was_ctrl;
    mmio_if.req_address   = off[17:2];
    mmio_if.req_length    = is8 ? 2'b01 : 2'b00;
    mmio_if.req_data      = d;
    mmio_if.req_tid       = 9'($urandom);
    mmio_if.mmio_wr_valid = 1'b1;
    done                  = with_done;
    exp_start = 0;
    exp_stop  = 0;
    was_ctrl  = model_write(off, is8, d);
    if (with_done && !was_ctrl && m_state == 2) m_state = 3;
    @(posedge clk);
    #1;
    mmio_if.mmio_wr_valid = 1'b0;
    done                  = 1'b0;
    txn++;
    $display("txn %0d %s: write off=%h len=%0d data=%h done=%0d", txn, tag, off, is8 ? 8 : 4, d, with_done);
    check_outputs(tag, 1'b0);
  endtask

  task automatic do_read(input logic [17:0] off, input bit is8, input logic [8:0] tid,
                         input bit with_done, input string tag);
    logic [63:0] exp;
    exp = model_read(off);
    mmio_if.req_address   = off[17:2];
    mmio_if.req_length    = is8 ? 2'b01 : 2'b00;
    mmio_if.req_tid       = tid;
    mmio_if.req_data      = 64'($urandom);
    mmio_if.mmio_rd_valid = 1'b1;
    done                  = with_done;
    exp_start = 0;
    exp_stop  = 0;
    if (with_done && m_state == 2) m_state = 3;
    @(posedge clk);
    #1;
    mmio_if.mmio_rd_valid = 1'b0;
    done                  = 1'b0;
    txn++;
    last_rsp = mmio_if.rsp_data;
    $display("txn %0d %s: read off=%h tid=%h data=%h done=%0d", txn, tag, off, tid, mmio_if.rsp_data, with_done);
    check_val({tag, "/rsp_tid"}, {55'h0, mmio_if.rsp_tid}, {55'h0, tid});
    check_val({tag, "/rsp_data"}, mmio_if.rsp_data, exp);
    check_outputs(tag, 1'b1);
  endtask

  task automatic do_idle(input bit with_done, input string tag);
    done      = with_done;
    exp_start = 0;
    exp_stop  = 0;
    if (with_done && m_state == 2) m_state = 3;
    @(posedge clk);
    #1;
    done = 1'b0;
    txn++;
    $display("txn %0d %s: idle done=%0d", txn, tag, with_done);
    check_outputs(tag, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    soft_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    soft_reset = 1'b0;
    model_reset();
    txn++;
    $display("txn %0d %s: soft reset", txn, tag);
    check_outputs(tag, 1'b0);
    check_val({tag, "/rsp_tid"}, {55'h0, mmio_if.rsp_tid}, 64'h0);
    check_val({tag, "/rsp_data"}, mmio_if.rsp_data, 64'h0);
  endtask

  int unsigned codes [8] = '{32'h0, 32'h1, 32'h3, 32'h3, 32'h7, 32'h7, 32'h2, 32'h1};

  initial begin
    soft_reset            = 1'b1;
    done                  = 1'b0;
    mmio_if.req_address   = '0;
    mmio_if.req_length    = '0;
    mmio_if.req_tid       = '0;
    mmio_if.req_data      = '0;
    mmio_if.mmio_rd_valid = 1'b0;
    mmio_if.mmio_wr_valid = 1'b0;
    last_rsp              = '0;
    model_reset();

    // Reset and identification
    apply_reset("reset");
    check_val("reset/afu_rst_const", {63'h0, afu_rst}, 64'h1);
    do_read(18'h008, 1, 9'h05A, 0, "id_l");
    check_val("id_l_const", last_rsp, 64'hFEDC_BA98_7654_3210);
    do_read(18'h010, 1, 9'h05A, 0, "id_h");
    check_val("id_h_const", last_rsp, 64'h0123_4567_89AB_CDEF);
    do_read(18'h000, 1, 9'h001, 0, "dfh");
    do_read(18'h100, 1, 9'h002, 0, "status_rst");
    check_val("status_rst_const", last_rsp, 64'h00);

    // Buffer table, including the first unmapped entry
    do_write(18'h150, 1, 64'hDEAD_BEEF_0000_1000, 0, "buf3_addr");
    check_val("buf3_addr_const", buf_addr[3], 64'hDEAD_BEEF_0000_1000);
    do_write(18'h158, 1, 64'h0000_0000_0000_4000, 0, "buf3_size");
    check_val("buf3_size_const", {32'h0, buf_size[3]}, 64'h4000);
    do_write(18'h160, 1, 64'h1234_5678_9ABC_DEF0, 0, "unmapped_wr");
    do_read(18'h160, 1, 9'h003, 0, "unmapped_rd");
    do_read(18'h150, 0, 9'h004, 0, "buf3_rd4");
    do_read(18'h15C, 0, 9'h005, 0, "buf3_size_rd_hi");

    // Partial-width write to DSM base
    do_write(18'h110, 1, 64'h1111_2222_3333_4444, 0, "dsm_full");
    do_write(18'h114, 0, 64'h0000_0000_AAAA_AAAA, 0, "dsm_hi4");
    check_val("dsm_partial_const", dsm_base, 64'hAAAA_AAAA_3333_4444);

    // Control sequence
    do_write(18'h118, 1, 64'h1, 0, "ctrl_idle");
    do_write(18'h118, 1, 64'h3, 0, "ctrl_start");
    do_read(18'h100, 1, 9'h006, 0, "status_run");
    check_val("status_run_const", last_rsp, 64'h21);
    do_idle(1, "done_pulse");
    do_read(18'h100, 1, 9'h007, 0, "status_done");
    check_val("status_done_const", last_rsp, 64'h32);
    do_write(18'h118, 1, 64'h3, 0, "ctrl_restart");

    // Write protection while running
    do_write(18'h120, 1, 64'h5555_6666_7777_8888, 0, "prot_wr");
    do_read(18'h100, 1, 9'h008, 0, "status_prot");
    check_val("status_prot_const", last_rsp, 64'h25);
    do_write(18'h118, 1, 64'h1, 0, "ctrl_clr");
    do_read(18'h100, 1, 9'h009, 0, "status_clr");
    check_val("status_clr_const", last_rsp, 64'h10);

    // Stop colliding with done, then mid-run reset
    do_write(18'h118, 1, 64'h3, 0, "ctrl_start2");
    do_write(18'h118, 1, 64'h7, 1, "stop_vs_done");
    do_read(18'h100, 1, 9'h00A, 0, "status_stop");
    check_val("status_stop_const", last_rsp, 64'h10);
    do_write(18'h118, 1, 64'h3, 0, "ctrl_start3");
    do_write(18'h118, 1, 64'h0, 0, "ctrl_reset");
    check_val("midrun_buf3_const", buf_addr[3], 64'hDEAD_BEEF_0000_1000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int          kind;
      bit          is8;
      bit          wd;
      logic [17:0] off;
      logic [63:0] d;
      kind = $urandom_range(0, 9);
      is8  = 1'($urandom_range(0, 1));
      wd   = ($urandom_range(0, 3) == 0);
      d    = {32'($urandom), 32'($urandom)};
      case (kind)
        0, 1, 2: off = is8 ? 18'(TBL_BASE + 8 * $urandom_range(0, 11)) : 18'(TBL_BASE + 4 * $urandom_range(0, 23));
        3:       off = is8 ? 18'h110 : 18'(18'h110 + 4 * $urandom_range(0, 1));
        4, 5: begin
          off = (!is8 && $urandom_range(0, 5) == 0) ? 18'h11C : 18'h118;
          d   = {32'($urandom), codes[$urandom_range(0, 7)]};
          if ($urandom_range(0, 9) == 0) d[31:0] = 32'($urandom);
        end
        6, 7: begin
          case ($urandom_range(0, 4))
            0:       off = 18'(8 * $urandom_range(0, 2));
            1:       off = 18'h100;
            2:       off = 18'(TBL_BASE + 4 * $urandom_range(0, 23));
            3:       off = 18'(18'h110 + 4 * $urandom_range(0, 3));
            default: off = 18'(4 * $urandom_range(0, 511));
          endcase
        end
        default: off = is8 ? 18'(8 * $urandom_range(0, 255)) : 18'(4 * $urandom_range(0, 511));
      endcase
      if (kind == 6 || kind == 7) do_read(off, is8, 9'($urandom), wd, "rnd_rd");
      else if (kind == 8) do_idle(wd, "rnd_idle");
      else do_write(off, is8, d, wd, "rnd_wr");
    end

    // SoftReset clears everything that a control reset keeps
    apply_reset("final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hc_csr_bank.md
# hc_csr_bank

Parametrised MMIO register bank and control sequencer for HardCloud accelerators, sitting between the CCI-P MMIO channels and the accelerator datapath. It decodes host MMIO writes into a buffer table of NUM_BUFFERS address/size pairs, a DSM base and a control FSM. It also answers MMIO reads (DFH, AFU ID, status, every writable CSR), generalising the fixed three-buffer, write-only decode to N buffers with read-back, partial-width writes and write protection.

## Interface
Parameters:
- NUM_BUFFERS, 3, buffer table entries (1..16)
- AFU_ID, 128'h0, value returned at AFU_ID_L/H
- BUFFER_BASE, 16'h120, byte offset of buffer 0; entry i address at BUFFER_BASE+16*i, size at BUFFER_BASE+16*i+8

Ports:
- clk  in  1  CCI-P clock; the block's only clock
- SoftReset  in  1  synchronous, active-high reset
- cp2af_sRx_c0  in  t_if_ccip_c0_Rx  MMIO requests (hdr, data, mmioRdValid, mmioWrValid)
- af2cp_sTx_c2  out  t_if_ccip_c2_Tx  MMIO read responses
- buf_addr  out  NUM_BUFFERS x 64  buffer base addresses
- buf_size  out  NUM_BUFFERS x 32  buffer sizes in bytes
- dsm_base  out  64  DSM base address
- afu_rst  out  1  accelerator reset, level
- start  out  1  one-cycle start pulse
- stop  out  1  one-cycle stop pulse
- done  in  1  accelerator completion pulse

## Operation
- Address map, byte offsets (hdr.address = byte>>2): 0x000 DFH (RO, AFU type, end-of-list), 0x008 AFU_ID_L, 0x010 AFU_ID_H, 0x100 STATUS (RO), 0x110 DSM_BASE (64b RW), 0x118 CONTROL (32b WO, reads 0), buffer table from BUFFER_BASE. Offsets ≥ 0x400 and unmapped offsets: writes dropped, reads return 0.
- Buffer index = (byte_offset − BUFFER_BASE) >> 4; byte bit 3 set selects the size register. Indices ≥ NUM_BUFFERS are unmapped.
- Write width from hdr.length: 8B writes the full 64b register. 4B writes the 32b half selected by word-address bit 0 (0 = low); the other half is kept. buf_size takes data[31:0] of any write reaching its low half; writes to its high half are dropped.
- Control FSM states: C_RESET, C_IDLE, C_RUN, C_DONE. Reset state C_RESET.
  - Code 0x0 from any state goes to C_RESET.
  - Code 0x1 from any state goes to C_IDLE.
  - Code 0x3 from C_IDLE or C_DONE goes to C_RUN and asserts start.
  - Code 0x7 from C_RUN goes to C_IDLE and asserts stop.
  - A done pulse in C_RUN goes to C_DONE.
  - Any other code, or a valid code in a non-listed state, is ignored.
- afu_rst = 1 exactly while in C_RESET.
- Write protect: in C_RUN, writes to DSM_BASE or the buffer table are dropped and set STATUS.wr_err (sticky). wr_err is cleared by control code 0x1.
- STATUS: [0] running (C_RUN), [1] done (C_DONE), [2] wr_err, [5:4] state encoding (RESET=0, IDLE=1, RUN=2, DONE=3), others 0.
- Simultaneous events: an MMIO control write in the same cycle as done takes priority and done is discarded. At most one MMIO request arrives per cycle, per CCI-P.
- Entering C_RESET mid-run keeps the buffer table and DSM_BASE; only SoftReset clears them.

## Timing
- SoftReset clears buf_addr, buf_size, dsm_base, wr_err and all af2cp_sTx_c2 fields to 0, and sets afu_rst=1. start=0, stop=0.
- Written registers are visible on outputs the cycle after mmioWrValid.
- FSM state, afu_rst, start and stop are registered. For a control write at cycle N they update at N+1, and start/stop are high for N+1 only.
- A done pulse at N changes STATUS at N+1.
- Read at cycle N: af2cp_sTx_c2.mmioRdValid=1 at N+1 for exactly one cycle, with hdr.tid equal to the request tid and data holding the full 64b register (4B reads are the same). Back-to-back reads give back-to-back responses.
- A read of STATUS at N returns the state as of the end of cycle N−1.

## Test plan
- Reset and ID: deassert SoftReset, read 0x008/0x010 with tid 0x5A → AFU_ID halves at +1 cycle with tid 0x5A; afu_rst=1 and STATUS=0x00.
- Buffer table, NUM_BUFFERS=4: 8B write 0xDEAD_BEEF_0000_1000 to 0x150 and size 0x4000 to 0x158 → buf_addr[3] and buf_size[3] updated next cycle; write to 0x160 → no output change, read returns 0.
- Partial write: 8B write 0x1111_2222_3333_4444 to 0x110, then 4B write 0xAAAA_AAAA at word address 0x45 → dsm_base=0xAAAA_AAAA_3333_4444.
- Control sequence: 0x1 then 0x3 → start high one cycle, STATUS=0x21; done pulse → STATUS=0x32; 0x3 again → second start pulse.
- Write protect: in C_RUN, write 0x120 → buf_addr[0] unchanged, STATUS[2]=1; write 0x1 → STATUS=0x10.
- Collision and mid-run reset: in C_RUN, drive done in the same cycle as a 0x7 write → stop pulse, state C_IDLE (not C_DONE); then 0x3 and 0x0 → afu_rst=1 next cycle, buffer table intact.
